// File: rtl/fir_sample_serializer.sv
// fir_sample_serializer
// Takes signed parallel samples from the FIR output over a valid/ready
// handshake. Each sample goes out MSB-first on a left-justified three-wire
// serial link (sclk, lrclk, sdata): once on the left channel, then again on
// the right. A one-deep holding register lets frames follow each other with
// no gap.
//
// Handshake: a transfer happens on a rising CLK edge when in_valid && in_ready.
// in_ready is simply !hold_full, so a sample offered while a frame is running
// is parked in the holding register. A sample offered while the block is idle,
// or on the very last cycle of a frame, goes straight into the shift register.
module fir_sample_serializer #(
  parameter int WL      = 9,
  parameter int CLK_DIV = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_data,
  output logic          sclk,
  output logic          lrclk,
  output logic          sdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int BW = (WL > 1) ? $clog2(WL) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BIT_MAX  = BW'(WL - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WL-1:0] sh_q, sh_d;
  logic [WL-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          sclk_q, sclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          busy_q, busy_d;

  logic          transfer;
  logic          load_pt;
  logic          start;
  logic [BW-1:0] bit_idx;

  assign in_ready  = !hold_full_q;
  assign transfer  = in_valid && !hold_full_q;
  // A new frame may start while idle, or on the edge that ends the final
  // cycle of the right channel, so back-to-back frames share no cycle.
  assign load_pt   = (state_q == S_IDLE) ||
                     ((state_q == S_RIGHT) && (bit_q == BIT_MAX) && (div_q == DIV_MAX));

  assign sclk      = sclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

  // Next-state: load/hold decisions, bit timing counters, and the output
  // values for the coming cycle (outputs are registered from these).
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    start       = 1'b0;

    if (load_pt) begin
      if (hold_full_q) begin
        sh_d        = hold_q;
        hold_full_d = 1'b0;
        start       = 1'b1;
      end else if (transfer) begin
        sh_d  = in_data;
        start = 1'b1;
      end
      div_d   = '0;
      bit_d   = '0;
      state_d = start ? S_LEFT : S_IDLE;
    end else begin
      if (transfer) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
      if (div_q == DIV_MAX) begin
        div_d = '0;
        if (bit_q == BIT_MAX) begin
          bit_d   = '0;
          state_d = S_RIGHT;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    bit_idx = BIT_MAX - bit_d;
    busy_d  = (state_d != S_IDLE);
    sclk_d  = busy_d && (div_d >= DIV_HALF);
    lrclk_d = (state_d == S_RIGHT);
    sdata_d = busy_d && sh_d[bit_idx];
  end

  // State, storage and registered outputs; reset discards any queued sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sclk_q      <= sclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Bench for fir_sample_serializer: directed and random sequences against a
// frame-level reference model (accepted samples, position within frame).
module tb_fir_sample_serializer;

  localparam int W  = 9;
  localparam int D  = 4;
  localparam int FL = 2 * W * D;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         in_ready, sclk, lrclk, sdata, busy;
  logic [1:0]   dbg_state;

  logic         in_valid2 = 1'b0;
  logic [3:0]   in_data2  = '0;
  logic         in_ready2, sclk2, lrclk2, sdata2, busy2;
  logic [1:0]   dbg_state2;

  fir_sample_serializer #(.WL(W), .CLK_DIV(D)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  fir_sample_serializer #(.WL(4), .CLK_DIV(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .sclk(sclk2), .lrclk(lrclk2), .sdata(sdata2),
    .busy(busy2), .dbg_state(dbg_state2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // A frame is 2*W*D cycles; the model only tracks which sample is playing,
  // how far into its frame we are, and which samples are waiting.
  bit           m_active;
  int           m_pos;
  logic [W-1:0] m_cur;
  logic [W-1:0] exp_q[$];

  function automatic bit m_ready();
    return (exp_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_cur    = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d);
    bit xfer;
    xfer = v && m_ready();
    if (!m_active || m_pos == FL - 1) begin
      if (exp_q.size() > 0) begin
        m_cur = exp_q.pop_front(); m_active = 1'b1; m_pos = 0;
      end else if (xfer) begin
        m_cur = d; m_active = 1'b1; m_pos = 0;
      end else begin
        m_active = 1'b0; m_pos = 0;
      end
    end else begin
      m_pos++;
      if (xfer) exp_q.push_back(d);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic e_sclk, e_lr, e_sd, e_busy;
    int ch, b, ph;
    if (m_active) begin
      ch = m_pos / (W * D);
      b  = (m_pos % (W * D)) / D;
      ph = m_pos % D;
      e_busy = 1'b1;
      e_sclk = (ph >= D / 2);
      e_lr   = (ch == 1);
      e_sd   = m_cur[W-1-b];
    end else begin
      e_busy = 1'b0; e_sclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0;
    end
    chk("busy",     {31'd0, busy},     {31'd0, e_busy});
    chk("sclk",     {31'd0, sclk},     {31'd0, e_sclk});
    chk("lrclk",    {31'd0, lrclk},    {31'd0, e_lr});
    chk("sdata",    {31'd0, sdata},    {31'd0, e_sd});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic         v;
    logic [W-1:0] d;
    v = in_valid;
    d = in_data;
    @(posedge CLK);
    model_step(v, d);
    #1;
    check_all();
  endtask

  // Offer one sample with in_valid held; returns after the accepting edge.
  task automatic send(input logic [W-1:0] d);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 400) begin
      acc = in_ready;
      tick();
      n++;
    end
    chk("send_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, lr_at;
    logic [7:0] bits2;
    logic [W-1:0] y;

    model_reset();
    #22;
    // Reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_sclk",     {31'd0, sclk},     32'd0);
    chk("rst_sdata",    {31'd0, sdata},    32'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles(3);

    // 0x155: alternating bits, busy for exactly one frame, lrclk at 36
    send(9'h155);
    in_valid = 1'b0;
    n = 0; lr_at = -1;
    while (busy && n < 200) begin
      if (lrclk && lr_at < 0) lr_at = n;
      n++;
      tick();
    end
    chk("frame_len_155", n, FL);
    chk("lrclk_at_155", lr_at, W * D);
    idle_cycles(5);

    // -1: sdata high for the whole frame
    send(9'h1FF);
    in_valid = 1'b0;
    n = 0; lr_at = -1;
    while (busy && n < 200) begin
      if (lrclk && lr_at < 0) lr_at = n;
      chk("sdata_all_ones", {31'd0, sdata}, 32'd1);
      n++;
      tick();
    end
    chk("frame_len_1ff", n, FL);
    chk("lrclk_at_1ff", lr_at, W * D);
    idle_cycles(4);

    // Continuous input: three back-to-back frames
    send(9'h100);
    send(9'h001);
    chk("ready_low_after_hold", {31'd0, in_ready}, 32'd0);
    send(9'h0AA);
    in_valid = 1'b0;
    idle_cycles(3 * FL + 10);

    // Accept on the last right-channel cycle: bypass load
    send(9'h0F3);
    in_valid = 1'b0;
    idle_cycles(FL - 1);
    y = 9'h12C;
    in_valid = 1'b1;
    in_data  = y;
    tick();
    in_valid = 1'b0;
    chk("bypass_busy",  {31'd0, busy},     32'd1);
    chk("bypass_msb",   {31'd0, sdata},    {31'd0, y[W-1]});
    chk("bypass_ready", {31'd0, in_ready}, 32'd1);
    chk("bypass_lrclk", {31'd0, lrclk},    32'd0);
    idle_cycles(FL + 5);

    // Reset at frame cycle 20 with a sample held
    send(9'h0C7);
    send(9'h138);
    in_valid = 1'b0;
    idle_cycles(19);
    chk("pre_rst_hold_full", {31'd0, in_ready}, 32'd0);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_busy",  {31'd0, busy},     32'd0);
    chk("rst_mid_sclk",  {31'd0, sclk},     32'd0);
    chk("rst_mid_lrclk", {31'd0, lrclk},    32'd0);
    chk("rst_mid_sdata", {31'd0, sdata},    32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles(2 * FL);

    // Random traffic with varying offered load
    for (int blk = 0; blk < 6; blk++) begin
      int p;
      p = $urandom_range(2, 100);
      for (int i = 0; i < 400; i++) begin
        in_valid = ($urandom_range(1, 100) <= p);
        in_data  = W'($urandom);
        tick();
      end
    end
    idle_cycles(2 * FL + 4);

    // WL=4, CLK_DIV=2 instance: 1001 sent as 1,0,0,1,1,0,0,1
    bits2 = 8'b1001_1001;
    in_valid2 = 1'b1;
    in_data2  = 4'b1001;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("p2_busy",  {31'd0, busy2},  32'd1);
      chk("p2_sdata", {31'd0, sdata2}, {31'd0, bits2[7 - i / 2]});
      chk("p2_sclk",  {31'd0, sclk2},  (i % 2));
      chk("p2_lrclk", {31'd0, lrclk2}, (i >= 8) ? 32'd1 : 32'd0);
      tick();
    end
    chk("p2_idle_busy",  {31'd0, busy2},  32'd0);
    chk("p2_idle_sdata", {31'd0, sdata2}, 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
